// File: rtl/traffic_phaser_if.sv
// Signal bundle for traffic_phaser.
//   run     : 1 = sequence advances, 0 = state and timer frozen
//   ped_req : level pedestrian request
//   light   : per-way lamp code {R,G,Y}, way k in light[k]
//   way     : index of the current or last-served way
//   walk    : high throughout the pedestrian walk phase
//   ped_ack : one-cycle pulse in the first walk cycle
// master = controller side (drives run/ped_req), slave = the phaser.
interface traffic_phaser_if #(
  parameter int NUM_WAYS = 4
);
  localparam int WAY_W = (NUM_WAYS > 2) ? $clog2(NUM_WAYS) : 1;

  logic                     run;
  logic                     ped_req;
  logic [NUM_WAYS-1:0][2:0] light;
  logic [WAY_W-1:0]         way;
  logic                     walk;
  logic                     ped_ack;

  modport master (output run, ped_req, input light, way, walk, ped_ack);
  modport slave  (input run, ped_req, output light, way, walk, ped_ack);
endinterface

// File: rtl/traffic_phaser.sv
// Traffic light phaser: cycles ALLRED -> GREEN -> YELLOW -> (WALK) -> ALLRED
// over NUM_WAYS approaches, one way at a time.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : traffic_phaser_if.slave (run, ped_req in; light, way, walk, ped_ack out)
// Lamps are decoded from registered state/way only, so no input reaches an
// output combinationally and reset blanks every way to red immediately.

// Per-way lamp decoder.
module traffic_phaser_lamp (
  input  logic       grn,
  input  logic       yel,
  output logic [2:0] code
);
  always_comb begin
    code = 3'b100;
    if (grn)      code = 3'b010;
    else if (yel) code = 3'b001;
  end
endmodule

module traffic_phaser #(
  parameter int NUM_WAYS = 4,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 6,
  parameter int CNT_W    = 8
) (
  input logic              clock,
  input logic              reset_n,
  traffic_phaser_if.slave  bus
);
  localparam int WAY_W = (NUM_WAYS > 2) ? $clog2(NUM_WAYS) : 1;

  // Timer reload values: a state lasting T cycles counts T-1 down to 0.
  localparam logic [CNT_W-1:0] LD_AR = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] LD_GR = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] LD_YE = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] LD_WK = CNT_W'(WALK_T - 1);
  localparam logic [WAY_W-1:0] LAST  = WAY_W'(NUM_WAYS - 1);

  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW, WALK} state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [WAY_W-1:0] way;
  logic             pend;
  logic             ack;
  logic             walk_q;
  logic [WAY_W-1:0] nxt_way;

  assign nxt_way = (way == LAST) ? '0 : way + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ALLRED;
      timer  <= LD_AR;
      way    <= '0;
      pend   <= 1'b0;
      ack    <= 1'b0;
      walk_q <= 1'b0;
    end else begin
      ack <= 1'b0;
      // Requests latch even while frozen; WALK entry below overrides this.
      if (bus.ped_req && state != WALK) pend <= 1'b1;
      if (bus.run && timer == '0) begin
        case (state)
          ALLRED: begin
            state <= GREEN;
            timer <= LD_GR;
          end
          GREEN: begin
            state <= YELLOW;
            timer <= LD_YE;
          end
          YELLOW: begin
            // A request arriving in the final yellow cycle still gets served.
            if (pend || bus.ped_req) begin
              state  <= WALK;
              timer  <= LD_WK;
              pend   <= 1'b0;
              ack    <= 1'b1;
              walk_q <= 1'b1;
            end else begin
              state <= ALLRED;
              timer <= LD_AR;
              way   <= nxt_way;
            end
          end
          default: begin
            state  <= ALLRED;
            timer  <= LD_AR;
            way    <= nxt_way;
            walk_q <= 1'b0;
          end
        endcase
      end else if (bus.run) begin
        timer <= timer - 1'b1;
      end
    end
  end

  assign bus.way     = way;
  assign bus.walk    = walk_q;
  assign bus.ped_ack = ack;

  for (genvar k = 0; k < NUM_WAYS; k++) begin : g_lamp
    localparam logic [WAY_W-1:0] K = WAY_W'(k);
    traffic_phaser_lamp u_lamp (
      .grn  (state == GREEN  && way == K),
      .yel  (state == YELLOW && way == K),
      .code (bus.light[k])
    );
  end
endmodule

// File: tb/tb_traffic_phaser.sv
// Bench for traffic_phaser with default parameters. A phase/age model
// predicts every output each cycle; directed literals pin the model.
module tb_traffic_phaser;
  localparam int NW = 4;
  localparam int GREEN_T = 8, YELLOW_T = 3, ALLRED_T = 1, WALK_T = 6;

  logic clock, reset_n;
  int   total = 0, bad = 0;
  int   ecnt = 0, base = 0;

  traffic_phaser_if #(.NUM_WAYS(NW)) bus ();

  traffic_phaser #(
    .NUM_WAYS(NW), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .WALK_T(WALK_T), .CNT_W(8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) ecnt++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0=all-red 1=green 2=yellow 3=walk, age = cycles spent so far.
  int dur [4] = '{ALLRED_T, GREEN_T, YELLOW_T, WALK_T};
  int m_ph = 0, m_age = 0, m_way = 0;
  bit m_pend = 0, m_ack = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = 0; m_age = 0; m_way = 0; m_pend = 0; m_ack = 0;
    end else begin
      bit old_pend;
      old_pend = m_pend;
      m_ack = 0;
      if (bus.ped_req && m_ph != 3) m_pend = 1;
      if (bus.run && m_age == dur[m_ph] - 1) begin
        m_age = 0;
        case (m_ph)
          0: m_ph = 1;
          1: m_ph = 2;
          2: if (old_pend || bus.ped_req) begin
               m_ph = 3; m_ack = 1; m_pend = 0;
             end else begin
               m_ph = 0; m_way = (m_way + 1) % NW;
             end
          default: begin m_ph = 0; m_way = (m_way + 1) % NW; end
        endcase
      end else if (bus.run) begin
        m_age++;
      end
    end
  end

  function automatic logic [3*NW-1:0] m_light();
    logic [3*NW-1:0] l;
    for (int k = 0; k < NW; k++) begin
      l[3*k +: 3] = 3'b100;
      if (k == m_way && m_ph == 1) l[3*k +: 3] = 3'b010;
      if (k == m_way && m_ph == 2) l[3*k +: 3] = 3'b001;
    end
    return l;
  endfunction

  always @(negedge clock) begin
    logic [3*NW-1:0] l;
    int nonred;
    l = bus.light;
    nonred = 0;
    for (int k = 0; k < NW; k++) if (l[3*k +: 3] != 3'b100) nonred++;
    chk("m_light", 32'(l), 32'(m_light()));
    chk("m_way", 32'(bus.way), 32'(m_way));
    chk("m_walk", 32'(bus.walk), 32'(m_ph == 3));
    chk("m_ack", 32'(bus.ped_ack), 32'(m_ack));
    chk("one_nonred", 32'(nonred <= 1), 32'd1);
  end

  task automatic at(int e);
    while (ecnt - base < e) @(negedge clock);
  endtask

  task automatic lit(string nm, logic [11:0] exp_l);
    chk(nm, 32'(bus.light), 32'(exp_l));
  endtask

  initial begin
    reset_n = 0; bus.run = 1; bus.ped_req = 0;
    repeat (3) @(negedge clock);
    lit("rst_light", 12'h924);
    chk("rst_walk", 32'(bus.walk), 0);
    reset_n = 1; base = ecnt;
    lit("rel_allred", 12'h924);
    chk("rel_way", 32'(bus.way), 0);
    at(1);  lit("w0_green", 12'h922);
    at(8);  lit("w0_green_last", 12'h922);
    at(9);  lit("w0_yellow", 12'h921);
    at(12); lit("allred_w1", 12'h924); chk("way1", 32'(bus.way), 1);
    at(13); lit("w1_green", 12'h914); bus.ped_req = 1;
    at(14); bus.ped_req = 0;
    at(24); lit("walk_red", 12'h924);
    chk("walk_on", 32'(bus.walk), 1); chk("ack_pulse", 32'(bus.ped_ack), 1);
    at(25); chk("ack_once", 32'(bus.ped_ack), 0); chk("walk_hold", 32'(bus.walk), 1);
    at(29); chk("walk_last", 32'(bus.walk), 1);
    at(30); chk("walk_off", 32'(bus.walk), 0); chk("way2", 32'(bus.way), 2);
    at(31); lit("w2_green", 12'h8A4);
    at(33); bus.run = 0; bus.ped_req = 1;
    at(34); bus.ped_req = 0;
    at(38); lit("frozen", 12'h8A4); bus.run = 1;
    at(43); lit("green13", 12'h8A4);
    at(44); lit("w2_yellow", 12'h864);
    at(47); chk("frz_walk", 32'(bus.walk), 1); chk("frz_ack", 32'(bus.ped_ack), 1);
    at(53); chk("way3", 32'(bus.way), 3);
    at(54); lit("w3_green", 12'h524);
    at(64); lit("w3_yel_last", 12'h324); bus.ped_req = 1;
    at(65); chk("late_walk", 32'(bus.walk), 1); chk("late_ack", 32'(bus.ped_ack), 1);
    at(70); bus.ped_req = 0;
    at(71); chk("wrap_way0", 32'(bus.way), 0); chk("late_walk_end", 32'(bus.walk), 0);
    at(72); lit("wrap_green", 12'h922);
    at(83); chk("no_2nd_walk", 32'(bus.walk), 0); chk("way1_again", 32'(bus.way), 1);
    at(97); bus.ped_req = 1;
    at(98); bus.ped_req = 0;
    at(104); lit("w2_yellow_b", 12'h864);
    @(posedge clock); #2 reset_n = 0;
    #1 lit("async_red", 12'h924);
    chk("async_way", 32'(bus.way), 0);
    chk("async_walk", 32'(bus.walk), 0);
    @(negedge clock); reset_n = 1; base = ecnt;
    at(1);  lit("re_green", 12'h922);
    at(12); chk("pend_lost", 32'(bus.walk), 0); chk("re_way1", 32'(bus.way), 1);
    at(13); lit("re_w1_green", 12'h914);
    at(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
